// File: rtl/credential_checker.sv
`default_nettype none
// ============================================================================
//  Module      : credential_checker
//  Description : Eight-entry id/password table with a sequential id scan, a
//                single-cycle password compare and a timed lockout after
//                repeated password failures.
//  Revision    : 1.0  initial release
// ============================================================================
module credential_checker #(
  parameter logic [15:0] DEFAULT_ID  = 16'h1234,
  parameter logic [15:0] DEFAULT_PWD = 16'h0000,
  parameter int unsigned MAX_FAIL    = 3,
  parameter logic [15:0] LOCK_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        idOut,
  input  logic [3:0]  Out1,
  input  logic [3:0]  Out2,
  input  logic [3:0]  Out3,
  input  logic [3:0]  Out4,
  input  logic        pwdOut,
  input  logic [3:0]  Pwd1,
  input  logic [3:0]  Pwd2,
  input  logic [3:0]  Pwd3,
  input  logic [3:0]  Pwd4,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [15:0] cfg_id,
  input  logic [15:0] cfg_pwd,
  input  logic        cfg_valid,
  output logic        idChecked,
  output logic        passChecked,
  output logic        id_fail,
  output logic        pwd_fail,
  output logic        lockout,
  output logic        busy,
  output logic [2:0]  match_index,
  output logic [1:0]  fail_count,
  output logic        cfg_err
);

  // Failure threshold narrowed to the width used for the counter arithmetic.
  localparam logic [2:0] c_MAX_FAIL = 3'(MAX_FAIL);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ID_SCAN = 3'd1,
    S_ID_WAIT = 3'd2,
    S_PWD_CMP = 3'd3,
    S_GRANTED = 3'd4,
    S_LOCKED  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  // Credential table
  logic        r_tab_valid [8];
  logic [15:0] r_tab_id    [8];
  logic [15:0] r_tab_pwd   [8];

  // Edge detectors and captured operands
  logic        r_id_prev;
  logic        r_pwd_prev;
  logic [15:0] r_id_cap;
  logic [15:0] r_pwd_cap;
  logic [2:0]  r_index;
  logic [15:0] r_lock_timer;

  // Registered outputs
  logic        r_id_checked;
  logic        r_pass_checked;
  logic        r_id_fail;
  logic        r_pwd_fail;
  logic        r_lockout;
  logic [2:0]  r_match_index;
  logic [1:0]  r_fail_count;
  logic        r_cfg_err;

  // Decoded conditions and control strobes
  logic        w_id_rise;
  logic        w_id_fall;
  logic        w_pwd_rise;
  logic        w_hit;
  logic        w_pwd_match;
  logic [2:0]  w_fail_inc;
  logic [1:0]  w_fail_next;
  logic        w_cfg_ok;
  logic        w_cfg_err;
  logic        w_cap_id;
  logic        w_scan_inc;
  logic        w_id_set;
  logic        w_id_fail;
  logic        w_cap_pwd;
  logic        w_grant;
  logic        w_pwd_fail;
  logic        w_lock;
  logic        w_lock_tick;
  logic        w_unlock;
  logic        w_release;

  assign w_id_rise   = idOut  & ~r_id_prev;
  assign w_id_fall   = ~idOut & r_id_prev;
  assign w_pwd_rise  = pwdOut & ~r_pwd_prev;
  assign w_hit       = r_tab_valid[r_index] && (r_tab_id[r_index] == r_id_cap);
  assign w_pwd_match = (r_pwd_cap == r_tab_pwd[r_match_index]);
  assign w_fail_inc  = {1'b0, r_fail_count} + 3'd1;
  // Counter saturates at the threshold instead of wrapping.
  assign w_fail_next = (w_fail_inc >= c_MAX_FAIL) ? c_MAX_FAIL[1:0] : w_fail_inc[1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state decode and per-cycle control strobes
  always_comb begin
    w_state_next = r_state;
    w_cfg_ok     = 1'b0;
    w_cfg_err    = 1'b0;
    w_cap_id     = 1'b0;
    w_scan_inc   = 1'b0;
    w_id_set     = 1'b0;
    w_id_fail    = 1'b0;
    w_cap_pwd    = 1'b0;
    w_grant      = 1'b0;
    w_pwd_fail   = 1'b0;
    w_lock       = 1'b0;
    w_lock_tick  = 1'b0;
    w_unlock     = 1'b0;
    w_release    = 1'b0;

    if (cfg_we) begin
      if ((r_state == S_IDLE) || (r_state == S_GRANTED)) w_cfg_ok  = 1'b1;
      else                                                w_cfg_err = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (w_id_rise) begin
          w_cap_id     = 1'b1;
          w_state_next = S_ID_SCAN;
        end
      end
      S_ID_SCAN: begin
        if (w_hit) begin
          w_id_set     = 1'b1;
          w_state_next = S_ID_WAIT;
        end else if (r_index == 3'd7) begin
          w_id_fail    = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_scan_inc   = 1'b1;
        end
      end
      S_ID_WAIT: begin
        // Withdrawing the id takes priority over a simultaneous password.
        if (w_id_fall) begin
          w_release    = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_pwd_rise) begin
          w_cap_pwd    = 1'b1;
          w_state_next = S_PWD_CMP;
        end
      end
      S_PWD_CMP: begin
        if (w_pwd_match) begin
          w_grant      = 1'b1;
          w_state_next = S_GRANTED;
        end else begin
          w_pwd_fail = 1'b1;
          if (w_fail_inc >= c_MAX_FAIL) begin
            w_lock       = 1'b1;
            w_state_next = S_LOCKED;
          end else begin
            w_state_next = S_ID_WAIT;
          end
        end
      end
      S_GRANTED: begin
        if (w_id_fall) begin
          w_release    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_LOCKED: begin
        w_lock_tick = 1'b1;
        if (r_lock_timer <= 16'd1) begin
          w_unlock     = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: table, edge detectors, captures, timer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        r_tab_valid[i] <= 1'b0;
        r_tab_id[i]    <= 16'h0000;
        r_tab_pwd[i]   <= 16'h0000;
      end
      r_tab_valid[0] <= 1'b1;
      r_tab_id[0]    <= DEFAULT_ID;
      r_tab_pwd[0]   <= DEFAULT_PWD;
      r_id_prev      <= 1'b0;
      r_pwd_prev     <= 1'b0;
      r_id_cap       <= 16'h0000;
      r_pwd_cap      <= 16'h0000;
      r_index        <= 3'd0;
      r_lock_timer   <= 16'h0000;
      r_id_checked   <= 1'b0;
      r_pass_checked <= 1'b0;
      r_id_fail      <= 1'b0;
      r_pwd_fail     <= 1'b0;
      r_lockout      <= 1'b0;
      r_match_index  <= 3'd0;
      r_fail_count   <= 2'd0;
      r_cfg_err      <= 1'b0;
    end else begin
      r_id_prev  <= idOut;
      r_pwd_prev <= pwdOut;
      r_id_fail  <= w_id_fail;
      r_pwd_fail <= w_pwd_fail;
      r_cfg_err  <= w_cfg_err;

      if (w_cfg_ok) begin
        r_tab_valid[cfg_addr] <= cfg_valid;
        r_tab_id[cfg_addr]    <= cfg_id;
        r_tab_pwd[cfg_addr]   <= cfg_pwd;
      end

      if (w_cap_id) begin
        r_id_cap       <= {Out1, Out2, Out3, Out4};
        r_index        <= 3'd0;
        r_id_checked   <= 1'b0;
        r_pass_checked <= 1'b0;
      end

      if (w_scan_inc) r_index <= r_index + 3'd1;

      if (w_id_set) begin
        r_id_checked  <= 1'b1;
        r_match_index <= r_index;
      end

      if (w_cap_pwd) r_pwd_cap <= {Pwd1, Pwd2, Pwd3, Pwd4};

      if (w_grant) begin
        r_pass_checked <= 1'b1;
        r_fail_count   <= 2'd0;
      end

      if (w_pwd_fail) r_fail_count <= w_fail_next;

      if (w_lock) begin
        r_id_checked <= 1'b0;
        r_lock_timer <= LOCK_CYCLES;
        r_lockout    <= 1'b1;
      end

      if (w_lock_tick) r_lock_timer <= r_lock_timer - 16'd1;

      if (w_unlock) begin
        r_lockout    <= 1'b0;
        r_fail_count <= 2'd0;
      end

      if (w_release) begin
        r_id_checked   <= 1'b0;
        r_pass_checked <= 1'b0;
      end
    end
  end

  assign idChecked   = r_id_checked;
  assign passChecked = r_pass_checked;
  assign id_fail     = r_id_fail;
  assign pwd_fail    = r_pwd_fail;
  assign lockout     = r_lockout;
  assign busy        = (r_state == S_ID_SCAN) || (r_state == S_PWD_CMP);
  assign match_index = r_match_index;
  assign fail_count  = r_fail_count;
  assign cfg_err     = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_credential_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_credential_checker
//  Description : Directed self-checking bench for credential_checker.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_credential_checker;

  logic        clk;
  logic        rst;
  logic        idOut;
  logic [3:0]  Out1, Out2, Out3, Out4;
  logic        pwdOut;
  logic [3:0]  Pwd1, Pwd2, Pwd3, Pwd4;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_id;
  logic [15:0] cfg_pwd;
  logic        cfg_valid;
  logic        idChecked;
  logic        passChecked;
  logic        id_fail;
  logic        pwd_fail;
  logic        lockout;
  logic        busy;
  logic [2:0]  match_index;
  logic [1:0]  fail_count;
  logic        cfg_err;

  int errors = 0;
  int checks = 0;

  credential_checker #(
    .DEFAULT_ID (16'h1234),
    .DEFAULT_PWD(16'h0000),
    .MAX_FAIL   (3),
    .LOCK_CYCLES(16'd10)
  ) dut (
    .clk(clk), .rst(rst),
    .idOut(idOut), .Out1(Out1), .Out2(Out2), .Out3(Out3), .Out4(Out4),
    .pwdOut(pwdOut), .Pwd1(Pwd1), .Pwd2(Pwd2), .Pwd3(Pwd3), .Pwd4(Pwd4),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_id(cfg_id), .cfg_pwd(cfg_pwd),
    .cfg_valid(cfg_valid),
    .idChecked(idChecked), .passChecked(passChecked), .id_fail(id_fail),
    .pwd_fail(pwd_fail), .lockout(lockout), .busy(busy),
    .match_index(match_index), .fail_count(fail_count), .cfg_err(cfg_err)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; inputs change and outputs are sampled 1 ns later.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_id(input logic [15:0] v);
    {Out1, Out2, Out3, Out4} = v;
  endtask

  task automatic set_pwd(input logic [15:0] v);
    {Pwd1, Pwd2, Pwd3, Pwd4} = v;
  endtask

  task automatic cfg(input logic [2:0] a, input logic [15:0] id, input logic [15:0] pw,
                     input logic v);
    cfg_we = 1'b1; cfg_addr = a; cfg_id = id; cfg_pwd = pw; cfg_valid = v;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".idChecked"},   {15'd0, idChecked},   16'd0);
    chk({tag, ".passChecked"}, {15'd0, passChecked}, 16'd0);
    chk({tag, ".id_fail"},     {15'd0, id_fail},     16'd0);
    chk({tag, ".pwd_fail"},    {15'd0, pwd_fail},    16'd0);
    chk({tag, ".lockout"},     {15'd0, lockout},     16'd0);
    chk({tag, ".busy"},        {15'd0, busy},        16'd0);
    chk({tag, ".match_index"}, {13'd0, match_index}, 16'd0);
    chk({tag, ".fail_count"},  {14'd0, fail_count},  16'd0);
    chk({tag, ".cfg_err"},     {15'd0, cfg_err},     16'd0);
  endtask

  initial begin
    rst = 1'b1; idOut = 1'b0; pwdOut = 1'b0;
    set_id(16'h0000); set_pwd(16'h0000);
    cfg_we = 1'b0; cfg_addr = 3'd0; cfg_id = 16'h0; cfg_pwd = 16'h0; cfg_valid = 1'b0;
    step(2);
    chk_all_zero("reset");
    rst = 1'b0;
    step(1);

    // Default entry 0: id 1234, password 0000
    set_id(16'h1234); idOut = 1'b1;            // cycle T
    step(1);
    chk("def.busy_scan",  {15'd0, busy},      16'd1);
    chk("def.id_T1",      {15'd0, idChecked}, 16'd0);
    step(1);                                    // T+2
    chk("def.id_T2",      {15'd0, idChecked}, 16'd1);
    chk("def.idx",        {13'd0, match_index}, 16'd0);
    set_pwd(16'h0000); pwdOut = 1'b1;           // cycle P
    step(1);
    chk("def.busy_cmp",   {15'd0, busy},        16'd1);
    chk("def.pass_P1",    {15'd0, passChecked}, 16'd0);
    step(1);
    chk("def.pass_P2",    {15'd0, passChecked}, 16'd1);
    chk("def.id_grant",   {15'd0, idChecked},   16'd1);
    pwdOut = 1'b0; idOut = 1'b0;
    step(1);
    chk("def.release_id", {15'd0, idChecked},   16'd0);
    chk("def.release_pw", {15'd0, passChecked}, 16'd0);

    // Entry 5 written in IDLE, found on the sixth compare
    cfg(3'd5, 16'hABCD, 16'h9876, 1'b1);
    step(1);
    cfg_we = 1'b0;
    chk("e5.cfg_err", {15'd0, cfg_err}, 16'd0);
    set_id(16'hABCD); idOut = 1'b1;             // cycle T
    step(6);
    chk("e5.id_T6", {15'd0, idChecked}, 16'd0);
    step(1);
    chk("e5.id_T7", {15'd0, idChecked}, 16'd1);
    chk("e5.idx",   {13'd0, match_index}, 16'd5);
    set_pwd(16'h9876); pwdOut = 1'b1;
    step(2);
    chk("e5.pass", {15'd0, passChecked}, 16'd1);
    pwdOut = 1'b0; idOut = 1'b0;
    step(1);

    // Unknown id, with a rejected write to entry 1 during the scan
    set_id(16'hFFFF); idOut = 1'b1;             // cycle T
    step(1);
    cfg(3'd1, 16'hFFFF, 16'h1111, 1'b1);        // T+1, in ID_SCAN
    step(1);
    cfg_we = 1'b0;
    chk("miss.cfg_err_T2", {15'd0, cfg_err}, 16'd1);
    step(1);
    chk("miss.cfg_err_T3", {15'd0, cfg_err}, 16'd0);
    step(5);                                    // T+8
    chk("miss.fail_T8", {15'd0, id_fail}, 16'd0);
    chk("miss.busy_T8", {15'd0, busy},    16'd1);
    step(1);                                    // T+9
    chk("miss.fail_T9", {15'd0, id_fail},   16'd1);
    chk("miss.id_T9",   {15'd0, idChecked}, 16'd0);
    chk("miss.fc_T9",   {14'd0, fail_count}, 16'd0);
    chk("miss.busy_T9", {15'd0, busy},      16'd0);
    step(1);
    chk("miss.fail_T10", {15'd0, id_fail}, 16'd0);
    idOut = 1'b0;
    step(1);

    // Write to entry 3 coincident with the id rise
    cfg(3'd3, 16'h5555, 16'h4321, 1'b1);
    set_id(16'h5555); idOut = 1'b1;             // cycle T
    step(1);
    cfg_we = 1'b0;
    chk("e3.cfg_err", {15'd0, cfg_err}, 16'd0);
    step(3);                                    // T+4
    chk("e3.id_T4", {15'd0, idChecked}, 16'd0);
    step(1);                                    // T+5
    chk("e3.id_T5", {15'd0, idChecked}, 16'd1);
    chk("e3.idx",   {13'd0, match_index}, 16'd3);
    idOut = 1'b0;                               // withdraw in ID_WAIT
    step(1);
    chk("e3.withdraw", {15'd0, idChecked}, 16'd0);

    // Invalidating the matched entry while granted keeps the session
    idOut = 1'b1;
    step(5);
    chk("gw.id", {15'd0, idChecked}, 16'd1);
    set_pwd(16'h4321); pwdOut = 1'b1;
    step(2);
    chk("gw.pass", {15'd0, passChecked}, 16'd1);
    pwdOut = 1'b0;
    cfg(3'd3, 16'h5555, 16'h4321, 1'b0);
    step(1);
    cfg_we = 1'b0;
    chk("gw.cfg_err", {15'd0, cfg_err},     16'd0);
    chk("gw.keep_id", {15'd0, idChecked},   16'd1);
    chk("gw.keep_pw", {15'd0, passChecked}, 16'd1);
    idOut = 1'b0;
    step(1);
    idOut = 1'b1;                               // entry 3 now invalid
    step(9);
    chk("gw.miss", {15'd0, id_fail}, 16'd1);
    idOut = 1'b0;
    step(1);

    // Three wrong passwords -> lockout of exactly 10 cycles
    set_id(16'h1234); idOut = 1'b1;
    step(2);
    chk("lk.id", {15'd0, idChecked}, 16'd1);
    set_pwd(16'h0001);
    pwdOut = 1'b1; step(1); pwdOut = 1'b0; step(1);
    chk("lk.pf1", {15'd0, pwd_fail},   16'd1);
    chk("lk.fc1", {14'd0, fail_count}, 16'd1);
    chk("lk.id1", {15'd0, idChecked},  16'd1);
    pwdOut = 1'b1; step(1); pwdOut = 1'b0; step(1);
    chk("lk.pf2", {15'd0, pwd_fail},   16'd1);
    chk("lk.fc2", {14'd0, fail_count}, 16'd2);
    pwdOut = 1'b1; step(1); pwdOut = 1'b0; step(1);   // C+1
    chk("lk.pf3",   {15'd0, pwd_fail},  16'd1);
    chk("lk.on",    {15'd0, lockout},   16'd1);
    chk("lk.id_cl", {15'd0, idChecked}, 16'd0);
    idOut = 1'b0; step(1);                      // C+2
    idOut = 1'b1; step(1);                      // C+3, rise ignored
    step(7);                                    // C+10
    chk("lk.on_C10", {15'd0, lockout},   16'd1);
    chk("lk.busy",   {15'd0, busy},      16'd0);
    chk("lk.noid",   {15'd0, idChecked}, 16'd0);
    step(1);                                    // C+11
    chk("lk.off",    {15'd0, lockout},    16'd0);
    chk("lk.fc_clr", {14'd0, fail_count}, 16'd0);
    step(1);
    chk("lk.no_queue", {15'd0, busy}, 16'd0);
    idOut = 1'b0;
    step(1);

    // Reset in the middle of a scan restores entry 0 defaults
    cfg(3'd0, 16'h7777, 16'h7777, 1'b1);
    step(1);
    cfg_we = 1'b0;
    set_id(16'hFFFF); idOut = 1'b1;
    step(3);
    rst = 1'b1; idOut = 1'b0;
    step(1);
    rst = 1'b0;
    chk_all_zero("rst_scan");
    set_id(16'h1234); idOut = 1'b1;
    step(2);
    chk("rst_scan.id",  {15'd0, idChecked},   16'd1);
    chk("rst_scan.idx", {13'd0, match_index}, 16'd0);

    // Reset while locked
    set_pwd(16'h0F0F);
    for (int k = 0; k < 3; k++) begin
      pwdOut = 1'b1; step(1); pwdOut = 1'b0; step(1);
    end
    chk("rst_lk.on", {15'd0, lockout}, 16'd1);
    step(3);
    rst = 1'b1; idOut = 1'b0;
    step(1);
    rst = 1'b0;
    chk_all_zero("rst_lk");
    idOut = 1'b1;
    step(2);
    chk("rst_lk.id", {15'd0, idChecked}, 16'd1);
    idOut = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
